mac48_seq_ctrl: RTL and testbench

Sequential signed multiply-accumulate controller for the Extended DLX TinyML datapath. It sits directly upstream of the shared 48-bit ripple adder: it drives that adder's A/B/Cin operands and consumes its SUM/Cout. It uses the adder for 16 radix-2 Booth steps to form a signed 16×16 product, then for one accumulate step into a 48-bit accumulator. It uses a start/busy/done handshake towards the DLX execute stage.

---
 rtl/mac48_pkg.sv | 41 ++++
 rtl/mac48_seq_ctrl_if.sv | 24 ++
 rtl/mac48_booth_sel.sv | 29 ++
 rtl/mac48_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_mac48_seq_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mac48_pkg.sv
// Shared types and constants for the sequential Booth multiply-accumulate controller.
package mac48_pkg;

   localparam int unsigned OP_W   = 16;
   localparam int unsigned ACC_W  = 48;
   localparam int unsigned STEP_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      BOOTH_ZERO = 2'd0,
      BOOTH_ADD  = 2'd1,
      BOOTH_SUB  = 2'd2
   } booth_t;

   // Operation captured on an accepted start
   typedef struct packed {
      logic             mode_mac;
      logic [OP_W-1:0]  op_b;
      logic [ACC_W-1:0] a_ext;
   } req_t;

   // Radix-2 Booth pair {b[i], b[i-1]} to adder action
   function automatic booth_t booth_decode(input logic [1:0] pair);
      case (pair)
         2'b01:   return BOOTH_ADD;
         2'b10:   return BOOTH_SUB;
         default: return BOOTH_ZERO;
      endcase
   endfunction

   function automatic logic [ACC_W-1:0] sext_op(input logic [OP_W-1:0] x);
      return {{(ACC_W-OP_W){x[OP_W-1]}}, x};
   endfunction

endpackage

// File: rtl/mac48_seq_ctrl_if.sv
// start/busy/done handshake between the DLX execute stage and the MAC controller.
interface mac48_seq_ctrl_if;
   import mac48_pkg::*;

   logic                   start;
   logic                   clr;
   logic                   mode_mac;
   logic [OP_W-1:0]        op_a;
   logic [OP_W-1:0]        op_b;
   logic                   busy;
   logic                   done;
   logic [ACC_W-1:0]       acc;

   modport master (
      output start, clr, mode_mac, op_a, op_b,
      input  busy, done, acc
   );

   modport slave (
      input  start, clr, mode_mac, op_a, op_b,
      output busy, done, acc
   );

endinterface

// File: rtl/mac48_booth_sel.sv
// Combinational Booth step operand select: B operand and carry-in for one MULT step.
module mac48_booth_sel
   import mac48_pkg::*;
(
   input  logic [ACC_W-1:0]  a,
   input  logic [STEP_W-1:0] step,
   input  logic [1:0]        pair,
   output logic [ACC_W-1:0]  add_b_c,
   output logic              add_cin_c
);

   logic [ACC_W-1:0] a_sh;

   always_comb begin
      a_sh      = a << step;
      add_b_c   = '0;
      add_cin_c = 1'b0;
      case (booth_decode(pair))
         BOOTH_ADD: add_b_c = a_sh;
         // Subtract as add of one's complement plus carry-in
         BOOTH_SUB: begin
            add_b_c   = ~a_sh;
            add_cin_c = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mac48_seq_ctrl.sv
// Sequential signed 16x16 Booth MAC controller driving an external 48-bit adder.
// Optional MAC48_ZERO_SKIP_EN: zero operands bypass the 16 Booth steps.
module mac48_seq_ctrl
   import mac48_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   mac48_seq_ctrl_if.slave   ctl,
   output logic [ACC_W-1:0]  add_a,
   output logic [ACC_W-1:0]  add_b,
   output logic              add_cin,
   input  logic [ACC_W-1:0]  add_sum,
   input  logic              add_cout
);

   state_t              state_q, state_d;
   req_t                req_q, req_d;
   logic [STEP_W-1:0]   step_q, step_d, next_step;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic                busy_q, busy_d, done_q, done_d;
   logic [ACC_W-1:0]    add_a_q, add_a_d, add_b_q, add_b_d;
   logic                add_cin_q, add_cin_d;

   logic [ACC_W-1:0]    bs_a, bs_add_b;
   logic [STEP_W-1:0]   bs_step;
   logic [1:0]          bs_pair;
   logic                bs_cin;
   logic                skip_c;
   logic                unused_cout;

   assign unused_cout = add_cout;
   assign next_step   = step_q + STEP_W'(1);

`ifdef MAC48_ZERO_SKIP_EN
   assign skip_c = (ctl.op_a == '0) || (ctl.op_b == '0);
`else
   assign skip_c = 1'b0;
`endif

   mac48_booth_sel u_booth_sel (
      .a         (bs_a),
      .step      (bs_step),
      .pair      (bs_pair),
      .add_b_c   (bs_add_b),
      .add_cin_c (bs_cin)
   );

   // Adder operands are registered one step ahead; add_a carries P during MULT
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      step_d    = step_q;
      acc_d     = acc_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      add_a_d   = '0;
      add_b_d   = '0;
      add_cin_d = 1'b0;
      bs_a      = req_q.a_ext;
      bs_step   = next_step;
      bs_pair   = {req_q.op_b[next_step], req_q.op_b[step_q]};

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (ctl.clr) acc_d = '0;
            if (ctl.start) begin
               req_d.mode_mac = ctl.mode_mac;
               req_d.op_b     = ctl.op_b;
               req_d.a_ext    = sext_op(ctl.op_a);
               step_d         = '0;
               busy_d         = 1'b1;
               bs_a           = sext_op(ctl.op_a);
               bs_step        = '0;
               bs_pair        = {ctl.op_b[0], 1'b0};
               if (skip_c) begin
                  state_d = ACC;
                  add_a_d = ctl.mode_mac ? acc_d : '0;
               end else begin
                  state_d   = MULT;
                  add_b_d   = bs_add_b;
                  add_cin_d = bs_cin;
               end
            end
         end
         MULT: begin
            busy_d = 1'b1;
            step_d = next_step;
            if (step_q == STEP_W'(OP_W-1)) begin
               state_d = ACC;
               add_a_d = req_q.mode_mac ? acc_q : '0;
               add_b_d = add_sum;
            end else begin
               add_a_d   = add_sum;
               add_b_d   = bs_add_b;
               add_cin_d = bs_cin;
            end
         end
         ACC: begin
            acc_d   = add_sum;
            done_d  = 1'b1;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q     <= '0;
         step_q    <= '0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         add_a_q   <= '0;
         add_b_q   <= '0;
         add_cin_q <= 1'b0;
      end else begin
         req_q     <= req_d;
         step_q    <= step_d;
         acc_q     <= acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         add_a_q   <= add_a_d;
         add_b_q   <= add_b_d;
         add_cin_q <= add_cin_d;
      end
   end

   assign ctl.busy = busy_q;
   assign ctl.done = done_q;
   assign ctl.acc  = acc_q;
   assign add_a    = add_a_q;
   assign add_b    = add_b_q;
   assign add_cin  = add_cin_q;

endmodule

// File: tb/tb_mac48_seq_ctrl.sv
// Scoreboard bench for mac48_seq_ctrl with a behavioural 48-bit adder and MAC reference model.
// Expected latency follows MAC48_ZERO_SKIP_EN when defined.
module tb_mac48_seq_ctrl;
   import mac48_pkg::*;

   typedef struct {
      logic [47:0] acc;
      int          t0;
      int          lat;
      int          busy;
   } exp_t;

`ifdef MAC48_ZERO_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [47:0] add_a, add_b, add_sum;
   logic        add_cin, add_cout;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          busy_run = 0;
   logic [47:0] model_acc = '0;
   exp_t        exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mac48_seq_ctrl_if ctl();

   assign {add_cout, add_sum} = 49'(add_a) + 49'(add_b) + 49'(add_cin);

   mac48_seq_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ctl      (ctl),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%012h expected 0x%012h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] rnd_op();
      case ($urandom_range(0, 7))
         0:       return 16'h0000;
         1:       return 16'h8000;
         2:       return 16'h7FFF;
         3:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   // Drive one start cycle and push the expected outcome
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic m, input logic c);
      exp_t        e;
      logic [47:0] pa, pb;
      bit          zero;
      ctl.start    = 1'b1;
      ctl.clr      = c;
      ctl.mode_mac = m;
      ctl.op_a     = a;
      ctl.op_b     = b;
      pa = {{32{a[15]}}, a};
      pb = {{32{b[15]}}, b};
      if (c) model_acc = '0;
      model_acc = m ? model_acc + pa * pb : pa * pb;
      zero   = (a == 16'h0) || (b == 16'h0);
      e.acc  = model_acc;
      e.t0   = cyc;
      e.lat  = (SKIP && zero) ? 2 : 18;
      e.busy = (SKIP && zero) ? 1 : 17;
      exp_q.push_back(e);
      @(negedge clk);
      ctl.start    = 1'b0;
      ctl.clr      = 1'b0;
      ctl.mode_mac = 1'($urandom);
      ctl.op_a     = 16'($urandom);
      ctl.op_b     = 16'($urandom);
   endtask

   task automatic wait_done();
      int n = 0;
      while (ctl.done !== 1'b1) begin
         if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done after %0d cycles expected within 40", n);
            return;
         end
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run(input logic [15:0] a, input logic [15:0] b, input logic m, input logic c);
      issue(a, b, m, c);
      wait_done();
   endtask

   // Monitor: pops the scoreboard on every done pulse
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         busy_run = 0;
      end else begin
         if (ctl.busy) busy_run++;
         else chk("idle_adder_ops", add_a | add_b | 48'(add_cin), '0);
         if (ctl.done) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_done: got done=1 expected no pending operation");
            end else begin
               e = exp_q.pop_front();
               chk("acc", ctl.acc, e.acc);
               chk("latency", 48'(cyc - e.t0), 48'(e.lat));
               chk("busy_cycles", 48'(busy_run), 48'(e.busy));
            end
            busy_run = 0;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      ctl.start    = 1'b0;
      ctl.clr      = 1'b0;
      ctl.mode_mac = 1'b0;
      ctl.op_a     = '0;
      ctl.op_b     = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 48'(ctl.busy), '0);
      chk("rst_done", 48'(ctl.done), '0);
      chk("rst_acc", ctl.acc, '0);
      rst_n = 1'b1;
      @(negedge clk);

      run(16'd3, 16'd5, 1'b0, 1'b0);
      chk("mul_3x5", ctl.acc, 48'd15);
      run(16'hFFFE, 16'd7, 1'b1, 1'b0);
      chk("mac_m2x7", ctl.acc, 48'd1);
      run(16'h8000, 16'h8000, 1'b0, 1'b0);
      chk("mul_min_min", ctl.acc, 48'h0000_4000_0000);
      run(16'h8000, 16'h7FFF, 1'b0, 1'b0);
      chk("mul_min_max", ctl.acc, 48'hFFFF_C000_8000);
      run(16'd4, 16'd4, 1'b1, 1'b1);
      chk("clr_start_done", ctl.acc, 48'd16);

      // start/clr while busy must be ignored
      issue(16'd5, 16'd6, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      ctl.start = 1'b1;
      ctl.clr   = 1'b1;
      ctl.op_a  = 16'd100;
      ctl.op_b  = 16'd100;
      @(negedge clk);
      ctl.start = 1'b0;
      ctl.clr   = 1'b0;
      wait_done();
      chk("busy_ignore", ctl.acc, 48'd46);

      run(16'hFFFF, 16'd1, 1'b0, 1'b0);
      chk("mul_m1", ctl.acc, 48'hFFFF_FFFF_FFFF);
      run(16'd1, 16'd1, 1'b1, 1'b0);
      chk("wrap_48", ctl.acc, 48'd0);

      run(16'd3, 16'd3, 1'b0, 1'b0);
      run(16'd0, 16'h1234, 1'b1, 1'b0);
      chk("mac_zero", ctl.acc, 48'd9);
      run(16'h0055, 16'd0, 1'b0, 1'b0);
      chk("mul_zero", ctl.acc, 48'd0);

      run(16'd2, 16'd3, 1'b0, 1'b0);
      @(negedge clk);
      ctl.clr = 1'b1;
      @(negedge clk);
      ctl.clr = 1'b0;
      model_acc = '0;
      run(16'd2, 16'd3, 1'b1, 1'b0);
      chk("clr_idle", ctl.acc, 48'd6);

      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run(rnd_op(), rnd_op(), 1'($urandom), ($urandom_range(0, 4) == 0));
      end

      // Reset in the middle of an operation
      issue(16'd9, 16'd9, 1'b1, 1'b0);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      model_acc = '0;
      #1;
      chk("midrst_busy", 48'(ctl.busy), '0);
      chk("midrst_acc", ctl.acc, '0);
      chk("midrst_done", 48'(ctl.done), '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("post_rst_busy", 48'(ctl.busy), '0);
      run(16'd7, 16'hFFFD, 1'b1, 1'b0);
      chk("post_rst_mac", ctl.acc, 48'hFFFF_FFFF_FFEB);

      repeat (5) @(negedge clk);
      chk("queue_empty", 48'(exp_q.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
